// File: rtl/frame_seq_pkg.sv
// Shared types and default sizing for the per-frame sequencer.
// The state encoding doubles as the externally visible phase code.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOGIC  = 2'd1,
        COMMIT = 2'd2,
        ENT    = 2'd3
    } seq_state_e;

    // 10 ms at 50 MHz
    localparam int unsigned TIMEOUT_CYCLES_DEF = 500000;
    localparam int unsigned DROP_W_DEF         = 8;
    localparam int unsigned FRAME_W_DEF        = 16;

    // Width of a counter that must reach cycles-1; never narrower than one bit.
    function automatic int unsigned wd_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and the game datapath blocks.
// Every signal except pause is a one-cycle pulse with no backpressure: a pulse
// is acted on in the cycle it is high or ignored; pause is a level.
interface frame_sequencer_if;

    logic frame_tick;
    logic pause;
    logic logic_start;
    logic logic_done;
    logic new_state;
    logic ent_start;
    logic ent_done;

    modport master (
        input  frame_tick,
        input  pause,
        input  logic_done,
        input  ent_done,
        output logic_start,
        output new_state,
        output ent_start
    );

    modport slave (
        output frame_tick,
        output pause,
        output logic_done,
        output ent_done,
        input  logic_start,
        input  new_state,
        input  ent_start
    );

endinterface

// File: rtl/frame_sequencer_phase_watchdog.sv
// Cycle counter that flags a phase which has run for TIMEOUT_CYCLES cycles.
// The count is zero in the first cycle after clear, so expiry marks the last allowed cycle.
module phase_watchdog
    import frame_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   CW    = wd_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Holds at the limit so a caller that ignores expiry never sees a wrap.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: game_logic update, operational memory commit, entity rebuild.
// Ticks arriving mid-frame are dropped and counted; hung phases are aborted by a watchdog.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned DROP_W         = DROP_W_DEF,
    parameter int unsigned FRAME_W        = FRAME_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    frame_sequencer_if.master  seq,
    output logic               busy,
    output logic [1:0]         phase,
    output logic [DROP_W-1:0]  overrun_count,
    output logic [FRAME_W-1:0] frame_count,
    output logic               timeout_flag
);

    seq_state_e state;
    seq_state_e state_next;

    logic logic_start_q;
    logic new_state_q;
    logic ent_start_q;
    logic busy_q;

    logic logic_start_next;
    logic new_state_next;
    logic ent_start_next;
    logic frame_done;
    logic abort;
    logic drop;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    phase_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    // A done pulse on the limit cycle takes priority over the abort.
    always_comb begin
        state_next       = state;
        logic_start_next = 1'b0;
        new_state_next   = 1'b0;
        ent_start_next   = 1'b0;
        frame_done       = 1'b0;
        abort            = 1'b0;
        case (state)
            IDLE: begin
                if (seq.frame_tick && !seq.pause) begin
                    state_next       = LOGIC;
                    logic_start_next = 1'b1;
                end
            end
            LOGIC: begin
                if (seq.logic_done) begin
                    state_next     = COMMIT;
                    new_state_next = 1'b1;
                end else if (wd_expired) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            COMMIT: begin
                state_next     = ENT;
                ent_start_next = 1'b1;
            end
            ENT: begin
                if (seq.ent_done) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end else if (wd_expired) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
        endcase
    end

    assign wd_enable = (state == LOGIC) || (state == ENT);
    assign wd_clear  = ((state_next == LOGIC) && (state != LOGIC)) ||
                       ((state_next == ENT)   && (state != ENT));
    assign drop      = seq.frame_tick && (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            logic_start_q <= 1'b0;
            new_state_q   <= 1'b0;
            ent_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_count <= '0;
            frame_count   <= '0;
            timeout_flag  <= 1'b0;
        end else begin
            state         <= state_next;
            logic_start_q <= logic_start_next;
            new_state_q   <= new_state_next;
            ent_start_q   <= ent_start_next;
            busy_q        <= (state_next != IDLE);
            if (drop && (overrun_count != {DROP_W{1'b1}})) begin
                overrun_count <= overrun_count + DROP_W'(1);
            end
            if (frame_done) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
            if (abort) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign seq.logic_start = logic_start_q;
    assign seq.new_state   = new_state_q;
    assign seq.ent_start   = ent_start_q;
    assign busy            = busy_q;
    assign phase           = state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboarded bench for frame_sequencer with a short watchdog and a 2-bit drop counter.
// A cycle-level reference model predicts pulses and status; a monitor compares each cycle.
module tb_frame_sequencer;

    localparam int TO       = 16;
    localparam int DW       = 2;
    localparam int FW       = 16;
    localparam int DROP_MAX = (1 << DW) - 1;
    localparam int SB       = FW + DW + 4;
    localparam int ST_W     = 32 + SB;
    localparam int EV_W     = 34;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic          busy;
    logic [1:0]    phase;
    logic [DW-1:0] overrun_count;
    logic [FW-1:0] frame_count;
    logic          timeout_flag;

    frame_sequencer_if sif ();

    frame_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .DROP_W        (DW),
        .FRAME_W       (FW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .seq          (sif),
        .busy         (busy),
        .phase        (phase),
        .overrun_count(overrun_count),
        .frame_count  (frame_count),
        .timeout_flag (timeout_flag)
    );

    // scoreboard state
    int vectors     = 0;
    int miscompares = 0;
    logic [EV_W-1:0] exp_q[$];   // {cycle, kind}: 0 logic_start, 1 new_state, 2 ent_start
    logic [ST_W-1:0] exp_st[$];  // {cycle, busy, phase, overrun, frames, timeout}

    // reference model: phase 0 idle, 1 logic, 2 commit, 3 ent; m_enter = first cycle of a wait phase
    int   m_state  = 0;
    int   m_enter  = 0;
    int   m_drops  = 0;
    int   m_frames = 0;
    logic m_tflag  = 1'b0;
    logic pause_lvl = 1'b0;

    function automatic logic [ST_W-1:0] pack_exp(input int t);
        logic [SB-1:0] s;
        s = {(m_state != 0), 2'(m_state), DW'(m_drops), FW'(m_frames), m_tflag};
        return {32'(t), s};
    endfunction

    task automatic model(input logic tk, input logic ld, input logic ed, input logic pz);
        int t;
        int ns;
        int kind;
        t    = cyc;
        ns   = m_state;
        kind = -1;
        if (tk && m_state != 0 && m_drops < DROP_MAX) m_drops++;
        if (m_state == 0) begin
            if (tk && !pz) begin
                ns = 1; m_enter = t + 1; kind = 0;
            end
        end else if (m_state == 1) begin
            if (ld) begin
                ns = 2; kind = 1;
            end else if (t - m_enter == TO - 1) begin
                ns = 0; m_tflag = 1'b1;
            end
        end else if (m_state == 2) begin
            ns = 3; m_enter = t + 1; kind = 2;
        end else begin
            if (ed) begin
                ns = 0; m_frames = (m_frames + 1) % (1 << FW);
            end else if (t - m_enter == TO - 1) begin
                ns = 0; m_tflag = 1'b1;
            end
        end
        m_state = ns;
        if (kind >= 0) exp_q.push_back({32'(t + 1), 2'(kind)});
        exp_st.push_back(pack_exp(t + 1));
    endtask

    // driver tasks
    task automatic step(input logic tk, input logic ld, input logic ed);
        reset          = 1'b0;
        sif.frame_tick = tk;
        sif.logic_done = ld;
        sif.ent_done   = ed;
        sif.pause      = pause_lvl;
        model(tk, ld, ed, pause_lvl);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset          = 1'b1;
            sif.frame_tick = 1'($urandom_range(0, 1));
            sif.logic_done = 1'($urandom_range(0, 1));
            sif.ent_done   = 1'($urandom_range(0, 1));
            sif.pause      = pause_lvl;
            m_state  = 0;
            m_enter  = 0;
            m_drops  = 0;
            m_frames = 0;
            m_tflag  = 1'b0;
            exp_st.push_back(pack_exp(cyc + 1));
            @(posedge clock);
            #1;
        end
    endtask

    // monitor
    logic [EV_W-1:0] ev_e;
    logic [ST_W-1:0] st_e;
    logic [SB-1:0]   st_got;

    task automatic check_pulse(input int kind, input string name);
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL pulse_%s: got pulse at cyc=%0d, want no pulse", name, cyc);
        end else begin
            ev_e = exp_q.pop_front();
            if (ev_e != {32'(cyc), 2'(kind)}) begin
                miscompares++;
                $display("FAIL pulse_%s: got cyc=%0d kind=%0d, want cyc=%0d kind=%0d",
                         name, cyc, kind, ev_e[EV_W-1:2], ev_e[1:0]);
            end
        end
    endtask

    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            ev_e = exp_q[0];
            if (int'(ev_e[EV_W-1:2]) >= cyc) break;
            ev_e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL pulse_missing: got nothing by cyc=%0d, want kind=%0d at cyc=%0d",
                     cyc, ev_e[1:0], ev_e[EV_W-1:2]);
        end
        if (sif.logic_start === 1'b1) check_pulse(0, "logic_start");
        if (sif.new_state === 1'b1)   check_pulse(1, "new_state");
        if (sif.ent_start === 1'b1)   check_pulse(2, "ent_start");
        if (exp_st.size() > 0) begin
            st_e = exp_st[0];
            if (int'(st_e[ST_W-1:SB]) <= cyc) begin
                st_e   = exp_st.pop_front();
                st_got = {busy, phase, overrun_count, frame_count, timeout_flag};
                vectors++;
                if (int'(st_e[ST_W-1:SB]) != cyc || st_got !== st_e[SB-1:0]) begin
                    miscompares++;
                    $display("FAIL status cyc=%0d: got busy=%0b phase=%0d overrun=%0d frames=%0d tflag=%0b, want busy=%0b phase=%0d overrun=%0d frames=%0d tflag=%0b (for cyc=%0d)",
                             cyc, busy, phase, overrun_count, frame_count, timeout_flag,
                             st_e[SB-1], st_e[SB-2 -: 2], st_e[FW+DW:FW+1], st_e[FW:1], st_e[0],
                             st_e[ST_W-1:SB]);
                end
            end
        end
    end

    // stimulus
    initial begin
        sif.frame_tick = 1'b0;
        sif.logic_done = 1'b0;
        sif.ent_done   = 1'b0;
        sif.pause      = 1'b0;
        @(posedge clock);
        #1;
        do_reset(2);

        // normal frame
        idle(8);
        step(1'b1, 1'b0, 1'b0);
        idle(9);
        step(1'b0, 1'b1, 1'b0);
        idle(9);
        step(1'b0, 1'b0, 1'b1);
        idle(3);

        // overrun: tick in LOGIC, tick together with ent_done
        step(1'b1, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b1);
        idle(3);

        // saturation of the drop counter, tick together with logic_done
        do_reset(1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b1);
        idle(2);

        // watchdog abort in LOGIC, then done exactly on the limit cycle in both phases
        do_reset(1);
        step(1'b1, 1'b0, 1'b0);
        idle(20);
        step(1'b1, 1'b0, 1'b0);
        idle(15);
        step(1'b0, 1'b1, 1'b0);
        idle(16);
        step(1'b0, 1'b0, 1'b1);
        idle(2);

        // watchdog abort in ENT
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(20);

        // pause and stray done pulses
        do_reset(1);
        pause_lvl = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        pause_lvl = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        pause_lvl = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        idle(2);
        pause_lvl = 1'b0;

        // reset mid-ENT, then a clean frame
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        do_reset(1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) pause_lvl = ~pause_lvl;
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1);
            end else begin
                step(1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 5) == 0),
                     1'($urandom_range(0, 5) == 0));
            end
        end

        // drain
        pause_lvl = 1'b0;
        idle(40);
        @(negedge clock);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pulse_drain: got %0d pulses never seen, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
